aes_round_controller: RTL and testbench
=======================================

Name: aes_round_controller

Overview:
- Sequencing controller for an iterative (one-round-per-cycle) AES-128 encrypt datapath.
- Accepts a plaintext block and its full expanded key through a valid/ready handshake, then latches both.
- Drives the round datapath through the initial AddRoundKey, rounds 1..9 and the final round, selecting the matching round key each cycle.
- Presents the ciphertext through a valid/ready output handshake. Sits between the key-expansion output and the shared round datapath.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds after the initial AddRoundKey.
- BLK_W, 128, block and round-key width in bits.
- EXP_W, (NUM_ROUNDS+1)*BLK_W = 1408, expanded-key width; derived, not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  plaintext and expanded key are valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  128  plaintext block.
- in_exp_key  in  1408  expanded key; round r occupies bits [128*r+127 : 128*r]; round 0 is bits [127:0].
- flush  in  1  synchronous abort of the current block.
- dp_en  out  1  datapath state register updates this cycle.
- dp_load  out  1  datapath selects dp_data (plaintext) instead of its own state.
- dp_final  out  1  final round; datapath skips MixColumns.
- dp_data  out  128  latched plaintext.
- dp_round_key  out  128  round key for the current step.
- dp_state  in  128  datapath registered state.
- out_valid  out  1  ciphertext is valid.
- out_ready  in  1  consumer accepts the ciphertext.
- out_data  out  128  ciphertext.
- round_idx  out  4  current round number, 0..10.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - LOAD: dp_en=1, dp_load=1, round 0 key.
  - ROUND: dp_en=1, keys 1..NUM_ROUNDS-1.
  - FINAL: dp_en=1, dp_final=1, key NUM_ROUNDS.
  - DONE: out_valid=1.
- Transitions:
  - IDLE -> LOAD when in_valid && in_ready. On that edge: latch in_data and in_exp_key, set round_idx=0.
  - LOAD -> ROUND; round_idx becomes 1.
  - ROUND: round_idx increments each cycle. ROUND -> FINAL on the edge where round_idx == NUM_ROUNDS-1, so FINAL has round_idx = NUM_ROUNDS.
  - FINAL -> DONE.
  - DONE -> IDLE when out_ready; round_idx cleared to 0.
- Latency: acceptance edge T, LOAD in cycle T+1, rounds 1..10 in cycles T+2..T+11, out_valid first high in cycle T+12. Minimum 13 cycles between acceptances.
- dp_round_key = latched key slice [round_idx]. The slice is a pure mux of the latched key register; it never comes directly from in_exp_key.
- dp_en, dp_load and dp_final are Moore outputs and are 0 in IDLE and DONE. dp_en=0 freezes the datapath state.
- out_data = dp_state while in DONE, 0 otherwise. It must stay stable while out_valid && !out_ready.
- in_exp_key and in_data may change freely after acceptance; the latched copies are used throughout.
- Backpressure: DONE holds indefinitely; in_ready stays 0 until the cycle after the output handshake.
- flush: in any non-IDLE state, go to IDLE on the next edge and clear round_idx. No out_valid is produced for the aborted block. flush in IDLE has no effect; in IDLE it also blocks acceptance that cycle (in_ready=0 when flush=1).
- flush together with out_ready in DONE: treated as a normal completion, since the handshake already occurred.
- rst assertion at any time, including mid-block: asynchronously force
  - state=IDLE, round_idx=0
  - key and data registers cleared to 0
  - all outputs 0, except in_ready=1 once rst deasserts.
- round_idx never exceeds NUM_ROUNDS. An illegal or unencoded state recovers to IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - the state enum (IDLE, LOAD, ROUND, FINAL, DONE)
  - AES_BLK_W=128, AES_NUM_ROUNDS=10, AES_EXP_W=1408
  - the round-index width of 4
- One natural sub-module: aes_round_key_select. It is a combinational selector that takes the 1408-bit latched key and round_idx and returns the 128-bit slice. The same selector is reused later by the decrypt controller with reversed indexing.

Test Plan:
- FIPS-197 C.1 vector (pt 00112233445566778899aabbccddeeff, key 000102...0f, expansion from the team's key-expansion block, golden round-datapath model) -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a with out_valid exactly 12 cycles after acceptance; dp_round_key equals slice r while round_idx=r.
- Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable and in_ready=0 throughout; completion on the 6th cycle; in_ready=1 the following cycle.
- Present two back-to-back blocks with in_valid held high and out_ready=1 -> second acceptance exactly 13 cycles after the first; both ciphertexts correct.
- Pulse flush while round_idx=5 -> IDLE next cycle, no out_valid; the next block still encrypts correctly.
- Assert rst asynchronously mid-round, between clock edges -> state and outputs reach reset values immediately; after release, in_ready=1 and a new block runs normally.
- Change in_exp_key and in_data every cycle after acceptance -> ciphertext matches the values latched at acceptance.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
// Package     : aes_pkg
// Description : Shared constants and controller state encoding for the
//               iterative AES-128 encrypt/decrypt controllers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_BLK_W      = 128;
  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_EXP_W      = (AES_NUM_ROUNDS + 1) * AES_BLK_W;
  localparam int AES_RIDX_W     = 4;

  // Controller sequencing states; codes 5..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } aes_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_round_key_select.sv
// ============================================================================
// Module      : aes_round_key_select
// Description : Combinational round-key slice selector. Returns the BLK_W-bit
//               slice r of the expanded key, slice 0 in the lowest bits.
//               Out-of-range indices return zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_key_select
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int BLK_W      = AES_BLK_W
) (
  input  logic [(NUM_ROUNDS+1)*BLK_W-1:0] i_exp_key,
  input  logic [AES_RIDX_W-1:0]           i_round_idx,
  output logic [BLK_W-1:0]                o_round_key
);

  // Pure mux across the key slices; no storage here.
  always_comb begin
    o_round_key = '0;
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      if (i_round_idx == AES_RIDX_W'(r)) begin
        o_round_key = i_exp_key[r*BLK_W +: BLK_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_round_controller.sv
// ============================================================================
// Module      : aes_round_controller
// Description : Sequencer for a one-round-per-cycle AES-128 encrypt datapath.
//               Latches plaintext and expanded key on acceptance, walks the
//               datapath through AddRoundKey, rounds 1..N-1 and the final
//               round, then presents the ciphertext with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_controller
  import aes_pkg::*;
#(
  parameter  int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter  int BLK_W      = AES_BLK_W,
  localparam int EXP_W      = (NUM_ROUNDS + 1) * BLK_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BLK_W-1:0]      in_data,
  input  logic [EXP_W-1:0]      in_exp_key,
  input  logic                  flush,
  output logic                  dp_en,
  output logic                  dp_load,
  output logic                  dp_final,
  output logic [BLK_W-1:0]      dp_data,
  output logic [BLK_W-1:0]      dp_round_key,
  input  logic [BLK_W-1:0]      dp_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BLK_W-1:0]      out_data,
  output logic [AES_RIDX_W-1:0] round_idx,
  output logic                  busy
);

  localparam logic [2:0] c_IDLE  = ST_IDLE;
  localparam logic [2:0] c_LOAD  = ST_LOAD;
  localparam logic [2:0] c_ROUND = ST_ROUND;
  localparam logic [2:0] c_FINAL = ST_FINAL;
  localparam logic [2:0] c_DONE  = ST_DONE;

  localparam logic [AES_RIDX_W-1:0] c_LAST_MID = AES_RIDX_W'(NUM_ROUNDS - 1);
  localparam logic [AES_RIDX_W-1:0] c_FINAL_IDX = AES_RIDX_W'(NUM_ROUNDS);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [AES_RIDX_W-1:0] r_round;
  logic [AES_RIDX_W-1:0] w_round_nxt;
  logic [BLK_W-1:0]      r_data;
  logic [EXP_W-1:0]      r_key;
  logic                  w_accept;

  // Acceptance is blocked by flush and held off while reset is asserted.
  assign in_ready = (r_state == c_IDLE) && !flush && !rst;
  assign w_accept = in_valid && in_ready;

  // Next-state and round-index sequencing; flush overrides every busy state.
  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_LOAD;
          w_round_nxt = '0;
        end
      end
      c_LOAD: begin
        w_state_nxt = c_ROUND;
        w_round_nxt = AES_RIDX_W'(1);
      end
      c_ROUND: begin
        // Compare with >= so a corrupted index can never run past the last key.
        if (r_round >= c_LAST_MID) begin
          w_state_nxt = c_FINAL;
          w_round_nxt = c_FINAL_IDX;
        end else begin
          w_round_nxt = r_round + AES_RIDX_W'(1);
        end
      end
      c_FINAL: begin
        w_state_nxt = c_DONE;
      end
      c_DONE: begin
        if (out_ready) begin
          w_state_nxt = c_IDLE;
          w_round_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_round_nxt = '0;
      end
    endcase
    // In DONE with out_ready the handshake already happened, so the result
    // of a simultaneous flush is the same normal return to IDLE.
    if (flush && (r_state != c_IDLE)) begin
      w_state_nxt = c_IDLE;
      w_round_nxt = '0;
    end
  end

  // State and round-index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Operand latches; inputs may change freely once a block is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_key  <= '0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_key  <= in_exp_key;
    end
  end

  aes_round_key_select #(
    .NUM_ROUNDS (NUM_ROUNDS),
    .BLK_W      (BLK_W)
  ) u_key_sel (
    .i_exp_key   (r_key),
    .i_round_idx (r_round),
    .o_round_key (dp_round_key)
  );

  assign dp_en     = (r_state == c_LOAD) || (r_state == c_ROUND) || (r_state == c_FINAL);
  assign dp_load   = (r_state == c_LOAD);
  assign dp_final  = (r_state == c_FINAL);
  assign dp_data   = r_data;
  assign out_valid = (r_state == c_DONE);
  // The datapath is frozen in DONE (dp_en=0), so this holds under backpressure.
  assign out_data  = (r_state == c_DONE) ? dp_state : '0;
  assign round_idx = r_round;
  assign busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_aes_round_controller.sv
// ============================================================================
// Module      : tb_aes_round_controller
// Description : Directed self-checking bench for aes_round_controller with a
//               behavioural AES round datapath and key expansion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_controller;
  import aes_pkg::*;

  localparam int NR = 10;
  localparam int BW = 128;
  localparam int EW = (NR + 1) * BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [EW-1:0] in_exp_key;
  logic          flush;
  logic          dp_en;
  logic          dp_load;
  logic          dp_final;
  logic [BW-1:0] dp_data;
  logic [BW-1:0] dp_round_key;
  logic [BW-1:0] dp_state;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [3:0]    round_idx;
  logic          busy;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_RK = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_RK  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  aes_round_controller #(
    .NUM_ROUNDS (NR),
    .BLK_W      (BW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_exp_key   (in_exp_key),
    .flush        (flush),
    .dp_en        (dp_en),
    .dp_load      (dp_load),
    .dp_final     (dp_final),
    .dp_data      (dp_data),
    .dp_round_key (dp_round_key),
    .dp_state     (dp_state),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .round_idx    (round_idx),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural AES helpers ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, r;
    t = x; r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [EW-1:0] expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [EW-1:0] e;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) e[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return e;
  endfunction

  // Golden round datapath driven by the controller.
  always @(posedge clk or posedge rst) begin
    if (rst) dp_state <= '0;
    else if (dp_en) begin
      if (dp_load)       dp_state <= dp_data ^ dp_round_key;
      else if (dp_final) dp_state <= shift_rows(sub_bytes(dp_state)) ^ dp_round_key;
      else               dp_state <= mix_cols(shift_rows(sub_bytes(dp_state))) ^ dp_round_key;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One block: accept, check every round step, optional backpressure, complete.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] ct, input logic [127:0] rk10,
                           input int hold, input bit scramble);
    logic [EW-1:0] ek;
    int n, acc;
    ek = expand(key);
    @(negedge clk);
    in_data = pt; in_exp_key = ek; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    chk("accept_ready", in_ready, 1);
    acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      if (scramble) begin
        in_data = {$urandom, $urandom, $urandom, $urandom};
        for (int j = 0; j < 44; j++) in_exp_key[32*j +: 32] = $urandom;
      end
      if (dp_en) begin
        chk("round_idx", round_idx, cyc - acc - 1);
        chk("round_key", dp_round_key, ek[round_idx*128 +: 128]);
        chk("dp_load", dp_load, (cyc - acc == 1));
        if (dp_final) chk("rk_final", dp_round_key, rk10);
      end
      @(negedge clk); n++;
    end
    chk("latency", cyc - acc, 12);
    chk("out_data", out_data, ct);
    chk("ready_in_done", in_ready, 0);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, ct);
      chk("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_ready", in_ready, 1);
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    int n, acc1, acc2, seen;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_exp_key = '0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_round_idx", round_idx, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_dp_en", dp_en, 0);
    chk("rel_dp_data", dp_data, 0);

    // FIPS-197 vectors, plain and with backpressure.
    run_block(C1_PT, C1_K, C1_CT, C1_RK, 1, 1'b0);
    run_block(B_PT, B_K, B_CT, B_RK, 5, 1'b0);
    // Inputs churn after acceptance.
    run_block(C1_PT, C1_K, C1_CT, C1_RK, 1, 1'b1);

    // Back-to-back with in_valid held high.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_data = C1_PT; in_exp_key = expand(C1_K);
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    acc1 = cyc;
    @(negedge clk);
    in_data = B_PT; in_exp_key = expand(B_K);
    n = 0; seen = 0;
    while (!in_ready && n < 40) begin
      if (out_valid) begin chk("b2b_first_ct", out_data, C1_CT); seen++; end
      @(negedge clk); n++;
    end
    acc2 = cyc;
    chk("b2b_gap", acc2 - acc1, 13);
    chk("b2b_first_seen", seen, 1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin @(negedge clk); n++; end
    chk("b2b_latency", cyc - acc2, 12);
    chk("b2b_second_ct", out_data, B_CT);
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", busy, 0);

    // Flush at round 5.
    @(negedge clk);
    in_valid = 1'b1; in_data = B_PT; in_exp_key = expand(B_K);
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd5 && n < 30) begin @(negedge clk); n++; end
    chk("flush_at_r5", round_idx, 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_round", round_idx, 0);
    chk("flush_dp_en", dp_en, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("flush_no_valid", seen, 0);
    // flush in IDLE blocks acceptance.
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("flush_idle_ready", in_ready, 0);
    @(negedge clk);
    chk("flush_idle_busy", busy, 0);
    flush = 1'b0; in_valid = 1'b0;
    run_block(B_PT, B_K, B_CT, B_RK, 1, 1'b0);

    // Asynchronous reset mid-round.
    @(negedge clk);
    in_valid = 1'b1; in_data = C1_PT; in_exp_key = expand(C1_K);
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (round_idx != 4'd3 && n < 30) begin @(negedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_round", round_idx, 0);
    chk("arst_dp_en", dp_en, 0);
    chk("arst_key", dp_round_key, 0);
    chk("arst_data", dp_data, 0);
    chk("arst_ready", in_ready, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_rel_ready", in_ready, 1);
    run_block(C1_PT, C1_K, C1_CT, C1_RK, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
